// File: rtl/vip_pkg.sv
// Shared definitions for the synthetic video frame generator: pattern codes,
// FSM states and the line/pixel counter width.
package vip_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_BOX     = 2'd3
  } pat_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Half-open interval test used by window-style patterns.
  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vip_pattern_rom.sv
// Combinational grey test-pattern generator: (pattern, h_cnt, v_cnt) -> Y.
// New patterns are added here without touching the frame timing logic.
module vip_pattern_rom
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic [1:0]       pattern,
  input  logic [CNT_W-1:0] h_cnt,
  input  logic [CNT_W-1:0] v_cnt,
  output logic [7:0]       y
);

  localparam logic [CNT_W-1:0] BOX_X0 = CNT_W'(IMG_HDISP / 4);
  localparam logic [CNT_W-1:0] BOX_X1 = CNT_W'(3 * IMG_HDISP / 4);
  localparam logic [CNT_W-1:0] BOX_Y0 = CNT_W'(IMG_VDISP / 4);
  localparam logic [CNT_W-1:0] BOX_Y1 = CNT_W'(3 * IMG_VDISP / 4);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves y
    // unassigned, which would otherwise infer a latch.
    y = 8'h00;
    case (pat_e'(pattern))
      PAT_HRAMP:   y = h_cnt[7:0];
      PAT_VRAMP:   y = v_cnt[7:0];
      PAT_CHECKER: y = (h_cnt[3] ^ v_cnt[3]) ? 8'hFF : 8'h00;
      PAT_BOX:     y = (in_range(h_cnt, BOX_X0, BOX_X1) &&
                        in_range(v_cnt, BOX_Y0, BOX_Y1)) ? 8'hFF : 8'h00;
      default:     y = 8'h00;
    endcase
  end

endmodule

// File: rtl/vip_frame_stream_generator.sv
// Synthetic CMOS-style video source (vsync/href/clken/Y) with blanking and
// selectable grey patterns. Optional frame stamp: define VIP_GEN_FRAME_STAMP_EN.
module vip_frame_stream_generator
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 160,
  parameter int V_BLANK   = 45,
  parameter int CLKEN_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       per_frame_vsync,
  output logic       per_frame_href,
  output logic       per_frame_clken,
  output logic [7:0] per_img_Y,
  output logic       frame_done,
  output logic       busy
`ifdef VIP_GEN_FRAME_STAMP_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(IMG_HDISP + H_BLANK - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(IMG_VDISP + V_BLANK - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(IMG_VDISP);
  localparam logic [CNT_W-1:0] H_PIX_LS = CNT_W'(IMG_HDISP - 1);
  localparam logic [CNT_W-1:0] V_PIX_LS = CNT_W'(IMG_VDISP - 1);
  localparam logic [3:0]       DIV_LAST = 4'(CLKEN_DIV - 1);

  state_e           state;
  logic [3:0]       div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [1:0]       pat_q;
  logic             last_pix_q;

  logic       tick;
  logic       h_wrap;
  logic       frame_wrap;
  logic       act_v;
  logic       href_c;
  logic       clken_c;
  logic       last_pix_c;
  logic [7:0] pat_y;
  logic [7:0] pix_y;

  // tick is gated by RUN so a divide-by-1 divider cannot strobe in IDLE.
  assign tick       = (state == RUN) && (div_cnt == DIV_LAST);
  assign h_wrap     = tick && (h_cnt == H_LAST);
  assign frame_wrap = h_wrap && (v_cnt == V_LAST);
  assign act_v      = (state == RUN) && (v_cnt < V_ACT);
  assign href_c     = act_v && (h_cnt < H_ACT);
  assign clken_c    = href_c && tick;
  assign last_pix_c = clken_c && (h_cnt == H_PIX_LS) && (v_cnt == V_PIX_LS);

  vip_pattern_rom #(
    .IMG_HDISP(IMG_HDISP),
    .IMG_VDISP(IMG_VDISP)
  ) u_pattern_rom (
    .pattern(pat_q),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .y      (pat_y)
  );

`ifdef VIP_GEN_FRAME_STAMP_EN
  logic [7:0] frame_cnt_q;
  logic       frame_start;

  assign frame_start = enable && ((state == IDLE) || frame_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= 8'h00;
    else if (frame_start) frame_cnt_q <= frame_cnt_q + 8'h01;
  end

  assign frame_cnt = frame_cnt_q;
  // The counter is bumped at frame start, so pixel (0,0) sees the new value.
  assign pix_y = ((h_cnt == '0) && (v_cnt == '0)) ? frame_cnt_q : pat_y;
`else
  assign pix_y = pat_y;
`endif

  // Frame FSM plus divider and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      div_cnt <= 4'd0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      pat_q   <= PAT_HRAMP;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= 4'd0;
          h_cnt   <= '0;
          v_cnt   <= '0;
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
            pat_q <= pattern_sel;
          end
        end
        RUN: begin
          div_cnt <= tick ? 4'd0 : div_cnt + 4'd1;
          if (tick) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          end
          // Enable is only honoured at the frame boundary; frames never truncate.
          if (frame_wrap) begin
            if (enable) begin
              pat_q <= pattern_sel;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Registered decode: outputs trail the counters by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_frame_vsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_clken <= 1'b0;
      per_img_Y       <= 8'h00;
      last_pix_q      <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      per_frame_vsync <= act_v;
      per_frame_href  <= href_c;
      per_frame_clken <= clken_c;
      if (clken_c) per_img_Y <= pix_y;
      last_pix_q      <= last_pix_c;
      frame_done      <= last_pix_q;
    end
  end

endmodule

// File: tb/tb_vip_frame_stream_generator.sv
// Self-checking bench: three generator instances of different geometry share
// stimulus and are compared every cycle against an arithmetic raster model.
module tb_vip_frame_stream_generator;

`ifdef VIP_GEN_FRAME_STAMP_EN
  localparam bit STAMP = 1'b1;
`else
  localparam bit STAMP = 1'b0;
`endif
  localparam int N = 3;

  typedef struct {
    int hd, vd, hb, vb, div;
  } geo_t;

  typedef struct {
    logic       run;
    int         pos;
    logic [1:0] pat;
    logic [7:0] fcnt;
    logic       vs, hr, ck, fd, busy, last_d;
    logic [7:0] y;
  } mdl_t;

  typedef struct {
    string name;
    int    dut;
    int    field;
    int    exp;
  } row_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] pattern_sel;

  logic       vs[N], hr[N], ck[N], fd[N], bz[N];
  logic [7:0] y[N];
`ifdef VIP_GEN_FRAME_STAMP_EN
  logic [7:0] fc[N];
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    vip_frame_stream_generator #(
      .IMG_HDISP(gi == 2 ? 24 : 8),
      .IMG_VDISP(gi == 2 ? 12 : 4),
      .H_BLANK  (4),
      .V_BLANK  (2),
      .CLKEN_DIV(gi == 0 ? 1 : (gi == 1 ? 3 : 2))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .pattern_sel    (pattern_sel),
      .per_frame_vsync(vs[gi]),
      .per_frame_href (hr[gi]),
      .per_frame_clken(ck[gi]),
      .per_img_Y      (y[gi]),
      .frame_done     (fd[gi]),
      .busy           (bz[gi])
`ifdef VIP_GEN_FRAME_STAMP_EN
      ,
      .frame_cnt      (fc[gi])
`endif
    );
  end

  geo_t geo[N];
  mdl_t m[N];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd_seen[N], fd_t[N], st_hr[N], st_ck[N], st_vs[N], st_per[N];
  int   st_ff[N], st_bad[N], ck_total[N];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pixel(input geo_t g, input logic [1:0] pat,
                                           input int h, input int v);
    case (pat)
      2'd0:    return 8'(h % 256);
      2'd1:    return 8'(v % 256);
      2'd2:    return (((h / 8) % 2) != ((v / 8) % 2)) ? 8'hFF : 8'h00;
      default: return (h >= g.hd / 4 && h < 3 * g.hd / 4 &&
                       v >= g.vd / 4 && v < 3 * g.vd / 4) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Frame position is one linear cycle index; raster coordinates are derived.
  function automatic mdl_t model_step(input mdl_t mi, input geo_t g,
                                      input logic en, input logic [1:0] sel);
    mdl_t n;
    int   line_len, period, slot, h, v;
    logic tick;
    n        = mi;
    line_len = g.hd + g.hb;
    period   = line_len * (g.vd + g.vb) * g.div;
    slot     = mi.pos / g.div;
    h        = slot % line_len;
    v        = slot / line_len;
    tick     = mi.run && ((mi.pos % g.div) == g.div - 1);
    n.vs     = mi.run && (v < g.vd);
    n.hr     = n.vs && (h < g.hd);
    n.ck     = n.hr && tick;
    if (n.ck) n.y = (STAMP && h == 0 && v == 0) ? mi.fcnt : exp_pixel(g, mi.pat, h, v);
    n.fd     = mi.last_d;
    n.last_d = n.ck && (h == g.hd - 1) && (v == g.vd - 1);
    if (!mi.run) begin
      if (en) begin
        n.run = 1'b1; n.pos = 0; n.pat = sel; n.fcnt = mi.fcnt + 8'd1;
      end
    end else if (mi.pos == period - 1) begin
      n.pos = 0;
      if (en) begin
        n.pat = sel; n.fcnt = mi.fcnt + 8'd1;
      end else begin
        n.run = 1'b0;
      end
    end else begin
      n.pos = mi.pos + 1;
    end
    n.busy = n.run;
    return n;
  endfunction

  function automatic mdl_t model_reset();
    mdl_t r;
    r = '{run: 1'b0, pos: 0, pat: 2'd0, fcnt: 8'd0, vs: 1'b0, hr: 1'b0, ck: 1'b0,
          fd: 1'b0, busy: 1'b0, last_d: 1'b0, y: 8'd0};
    return r;
  endfunction

  function automatic logic all_idle();
    return !(bz[0] || bz[1] || bz[2]);
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      fd_seen[i] = 0; fd_t[i] = 0; st_hr[i] = 0; st_ck[i] = 0; st_vs[i] = 0;
      st_per[i] = 0; st_ff[i] = 0; st_bad[i] = 0; ck_total[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++)
      m[i] = rst_n ? model_step(m[i], geo[i], enable, pattern_sel) : model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      check("vsync", i, 32'(vs[i]), 32'(m[i].vs));
      check("href", i, 32'(hr[i]), 32'(m[i].hr));
      check("clken", i, 32'(ck[i]), 32'(m[i].ck));
      check("Y", i, 32'(y[i]), 32'(m[i].y));
      check("frame_done", i, 32'(fd[i]), 32'(m[i].fd));
      check("busy", i, 32'(bz[i]), 32'(m[i].busy));
`ifdef VIP_GEN_FRAME_STAMP_EN
      check("frame_cnt", i, 32'(fc[i]), 32'(m[i].fcnt));
`endif
      if (ck[i]) ck_total[i]++;
      if (fd_seen[i] == 1) begin
        st_hr[i] += int'(hr[i]);
        st_ck[i] += int'(ck[i]);
        st_vs[i] += int'(vs[i]);
        if (ck[i] && y[i] == 8'hFF) st_ff[i]++;
        if (ck[i] && y[i] != 8'hFF && y[i] != 8'h00) st_bad[i]++;
      end
      if (fd[i]) begin
        fd_seen[i]++;
        if (fd_seen[i] == 1) fd_t[i] = cyc;
        else if (fd_seen[i] == 2) st_per[i] = cyc - fd_t[i];
      end
    end
  endtask

  function automatic int stat_of(input int dut, input int field);
    case (field)
      0:       return st_hr[dut];
      1:       return st_ck[dut];
      2:       return st_vs[dut];
      default: return st_per[dut];
    endcase
  endfunction

  initial begin
    row_t rows[12];
    int   cnt;
    logic seen;

    geo[0] = '{hd: 8,  vd: 4,  hb: 4, vb: 2, div: 1};
    geo[1] = '{hd: 8,  vd: 4,  hb: 4, vb: 2, div: 3};
    geo[2] = '{hd: 24, vd: 12, hb: 4, vb: 2, div: 2};
    // One-frame window stats: href cycles, clkens, vsync cycles, period.
    rows[0]  = '{"href_cycles",  0, 0, 32};
    rows[1]  = '{"clken_count",  0, 1, 32};
    rows[2]  = '{"vsync_cycles", 0, 2, 48};
    rows[3]  = '{"frame_period", 0, 3, 72};
    rows[4]  = '{"href_cycles",  1, 0, 96};
    rows[5]  = '{"clken_count",  1, 1, 32};
    rows[6]  = '{"vsync_cycles", 1, 2, 144};
    rows[7]  = '{"frame_period", 1, 3, 216};
    rows[8]  = '{"href_cycles",  2, 0, 576};
    rows[9]  = '{"clken_count",  2, 1, 288};
    rows[10] = '{"vsync_cycles", 2, 2, 672};
    rows[11] = '{"frame_period", 2, 3, 784};

    for (int i = 0; i < N; i++) m[i] = model_reset();
    clear_stats();
    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Continuous horizontal-ramp frames, then the stats table.
    enable = 1'b1;
    for (int c = 0; c < 2000 && (fd_seen[0] < 2 || fd_seen[1] < 2 || fd_seen[2] < 2); c++)
      step();
    for (int r = 0; r < 12; r++)
      check(rows[r].name, rows[r].dut, 32'(stat_of(rows[r].dut, rows[r].field)),
            32'(rows[r].exp));

    // Switch to checkerboard mid-frame; the following full frame must be 00/FF.
    repeat (300) step();
    pattern_sel = 2'd2;
    clear_stats();
    for (int c = 0; c < 2000 && fd_seen[2] < 2; c++) step();
    check("checker_ff_pixels", 2, 32'(st_ff[2]), 32'd128);
    check("checker_other_pixels", 2, 32'(st_bad[2]), 32'd0);

    // Drop enable during line 1: the frame must still deliver every clken.
    enable = 1'b0;
    for (int c = 0; c < 2000 && !all_idle(); c++) step();
    check("idle_before_drop", 0, 32'(all_idle()), 32'd1);
    pattern_sel = 2'd0;
    clear_stats();
    enable = 1'b1;
    repeat (14) step();
    enable = 1'b0;
    for (int c = 0; c < 1000 && !all_idle(); c++) step();
    check("drop_clkens", 0, 32'(ck_total[0]), 32'd32);
    check("drop_clkens", 1, 32'(ck_total[1]), 32'd32);
    check("drop_clkens", 2, 32'(ck_total[2]), 32'd288);
    repeat (20) step();

    // Asynchronous reset at pixel (3,2) of dut0, then restart at (0,0).
    enable = 1'b1;
    repeat (28) step();
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_vsync", i, 32'(vs[i]), 32'd0);
      check("rst_href", i, 32'(hr[i]), 32'd0);
      check("rst_clken", i, 32'(ck[i]), 32'd0);
      check("rst_Y", i, 32'(y[i]), 32'd0);
      check("rst_busy", i, 32'(bz[i]), 32'd0);
    end
    repeat (2) step();
    rst_n = 1'b1;
    cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      cnt++;
      seen = ck[0];
    end
    check("restart_latency", 0, 32'(cnt), 32'd2);
    check("restart_first_Y", 0, 32'(y[0]), STAMP ? 32'd1 : 32'd0);

`ifdef VIP_GEN_FRAME_STAMP_EN
    // Three stamped frames from a fresh reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pattern_sel = 2'd0;
    for (int f = 1; f <= 3; f++) begin
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        step();
        seen = ck[0];
      end
      check("stamp_Y", 0, 32'(y[0]), 32'(f));
      check("stamp_frame_cnt", 0, 32'(fc[0]), 32'(f));
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        step();
        seen = fd[0];
      end
    end
`endif

    // Random enable/pattern traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      enable      = ($urandom_range(0, 99) < 85);
      pattern_sel = 2'($urandom_range(0, 3));
      rst_n       = ($urandom_range(0, 999) != 0);
      step();
      rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
